// File: rtl/dot_requant_i8.sv
// Group accumulator + int8 requantizer: sums n_blk dot-product results, rounds/shifts/saturates to int8.
// Optional: define DOT_REQUANT_RELU_EN to zero negative results before saturation.
module dot_requant_i8 #(
    parameter int bit_width   = 8,
    parameter int k           = 32,
    parameter int in_width    = 2*bit_width + $clog2(k),
    parameter int n_blk       = 4,
    parameter int acc_width   = in_width + $clog2(n_blk),
    parameter int shift_width = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic signed [in_width-1:0]    i_dp,
    input  logic                          i_dp_valid,
    output logic                          o_dp_ready,
    input  logic [shift_width-1:0]        i_shift,
    output logic signed [bit_width-1:0]   o_q,
    output logic                          o_q_valid,
    input  logic                          i_q_ready,
    output logic                          o_sat
);

    localparam int cnt_w = (n_blk > 1) ? $clog2(n_blk) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(n_blk - 1);
    localparam logic signed [acc_width:0] qmax = (acc_width+1)'(2**(bit_width-1) - 1);
    localparam logic signed [acc_width:0] qmin = (acc_width+1)'(-(2**(bit_width-1)));

    typedef enum logic [1:0] {ACC, RND, OUT} state_t;

    state_t                        state, state_d;
    logic [cnt_w-1:0]              cnt;
    logic signed [acc_width-1:0]   acc_p0;
    logic [shift_width-1:0]        shamt_p0;
    logic signed [acc_width-1:0]   dp_ext;
    logic                          beat, last_beat;

    // Round-half-up arithmetic right shift; shifts past the accumulator width collapse to the sign.
    function automatic logic signed [acc_width:0] round_shift(
        input logic signed [acc_width-1:0] a,
        input logic [shift_width-1:0]      sh
    );
        logic signed [acc_width:0] ext, bias;
        ext  = (acc_width+1)'(a);
        bias = '0;
        if (sh == '0)
            return ext;
        if (int'(sh) >= acc_width)
            return a[acc_width-1] ? '1 : '0;
        bias = (acc_width+1)'(1) << (sh - 1'b1);
        return (ext + bias) >>> sh;
    endfunction

    // Returns {clamped, q}.
    function automatic logic [bit_width:0] clamp(input logic signed [acc_width:0] s);
        logic signed [acc_width:0] v;
        v = s;
`ifdef DOT_REQUANT_RELU_EN
        if (v < 0)
            v = '0;
`endif
        if (v > qmax)
            return {1'b1, qmax[bit_width-1:0]};
        if (v < qmin)
            return {1'b1, qmin[bit_width-1:0]};
        return {1'b0, v[bit_width-1:0]};
    endfunction

    assign o_dp_ready = (state == ACC);
    assign beat       = i_dp_valid && o_dp_ready;
    assign last_beat  = beat && (cnt == last_cnt);
    assign dp_ext     = acc_width'(i_dp);

    always_comb begin
        state_d = state;
        case (state)
            ACC:     if (last_beat) state_d = RND;
            RND:     state_d = OUT;
            OUT:     if (i_q_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ACC;
        else
            state <= state_d;
    end

    // Stage p0: group accumulation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            acc_p0   <= '0;
            shamt_p0 <= '0;
        end else if (beat) begin
            cnt <= last_beat ? '0 : cnt + cnt_w'(1);
            if (cnt == '0) begin
                acc_p0   <= dp_ext;
                shamt_p0 <= i_shift;
            end else begin
                acc_p0 <= acc_p0 + dp_ext;
            end
        end
    end

    // Stage p1: requantized output register, held until handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q       <= '0;
            o_sat     <= 1'b0;
            o_q_valid <= 1'b0;
        end else if (state == RND) begin
            {o_sat, o_q} <= clamp(round_shift(acc_p0, shamt_p0));
            o_q_valid    <= 1'b1;
        end else if (state == OUT && i_q_ready) begin
            o_q_valid <= 1'b0;
        end
    end

endmodule
